// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS fetch front end.
//   INSTR_W      : instruction / address width
//   RESET_PC_DEF : value the external PC register takes on reset
//   EXC_VEC_DEF  : exception entry address
//   fetch_state_t: fetch sequencer state encoding
package mips_pkg;

  localparam int INSTR_W = 32;

  localparam logic [INSTR_W-1:0] RESET_PC_DEF = 32'h0000_3000;
  localparam logic [INSTR_W-1:0] EXC_VEC_DEF  = 32'h0000_4180;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    REQ  = 2'd1,
    FULL = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_skid.sv
// One-entry holding buffer for a fetched instruction and its address.
// Ports:
//   clk, reset (async, active-low)
//   load    : capture d_instr/d_pc at the edge
//   clear   : zero the contents (wins over load)
//   d_instr, d_pc : word and address to capture
//   q_instr, q_pc : buffered word and address
module fetch_skid
  import mips_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               clear,
  input  logic [INSTR_W-1:0] d_instr,
  input  logic [INSTR_W-1:0] d_pc,
  output logic [INSTR_W-1:0] q_instr,
  output logic [INSTR_W-1:0] q_pc
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_instr <= '0;
      q_pc    <= '0;
    end else if (clear) begin
      q_instr <= '0;
      q_pc    <= '0;
    end else if (load) begin
      q_instr <= d_instr;
      q_pc    <= d_pc;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch control: drives the external PC register (pc_en/npc),
// handshakes with instruction memory, and feeds the IF/ID stage. Branches
// use delay-slot semantics; exceptions vector to EXC_VEC; a one-entry skid
// buffer absorbs a word returned while IF/ID is stalled.
// Ports:
//   clk, reset (async, active-low)
//   pc                  : current PC register value (reset externally)
//   pc_en, npc          : PC load pulse and next value
//   imem_req            : fetch request at address pc
//   imem_ack, imem_rdata: same-cycle accept and instruction word
//   stall               : IF/ID cannot accept this cycle
//   redirect_valid/target : taken branch/jump from ID
//   exc_valid           : exception pulse
//   if_valid, if_instr, if_pc : instruction presented to IF/ID
//
// state | meaning
// BOOT  | first cycle after reset, no request
// REQ   | request outstanding, waiting for imem_ack
// FULL  | word parked in skid buffer, waiting for stall to drop
module fetch_sequencer
  import mips_pkg::*;
#(
  parameter logic [INSTR_W-1:0] EXC_VEC = EXC_VEC_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [INSTR_W-1:0] pc,
  output logic               pc_en,
  output logic [INSTR_W-1:0] npc,
  output logic               imem_req,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [INSTR_W-1:0] redirect_target,
  input  logic               exc_valid,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [INSTR_W-1:0] if_pc
);

  fetch_state_t state, state_nxt;

  logic               pend_redir, pend_redir_nxt;
  logic               pend_exc, pend_exc_nxt;
  logic [INSTR_W-1:0] tgt, tgt_nxt;
  logic               if_valid_nxt;
  logic [INSTR_W-1:0] if_instr_nxt, if_pc_nxt;

  logic               adv;
  logic               skid_load, skid_clear;
  logic [INSTR_W-1:0] skid_instr, skid_pc;
  logic [INSTR_W-1:0] npc_raw;

  fetch_skid u_skid (
    .clk     (clk),
    .reset   (reset),
    .load    (skid_load),
    .clear   (skid_clear),
    .d_instr (imem_rdata),
    .d_pc    (pc),
    .q_instr (skid_instr),
    .q_pc    (skid_pc)
  );

  // A same-cycle exception also selects the vector, since it advances at once
  // from BOOT/FULL/REQ+ack.
  always_comb begin
    if (pend_exc || exc_valid)  npc_raw = EXC_VEC;
    else if (redirect_valid)    npc_raw = redirect_target;
    else if (pend_redir)        npc_raw = tgt;
    else                        npc_raw = pc + 32'd4;
  end

  assign npc      = npc_raw & 32'hFFFF_FFFC;
  assign pc_en    = adv & reset;
  assign imem_req = (state == REQ) & reset;

  always_comb begin
    state_nxt      = state;
    adv            = 1'b0;
    skid_load      = 1'b0;
    skid_clear     = 1'b0;
    if_valid_nxt   = if_valid;
    if_instr_nxt   = if_instr;
    if_pc_nxt      = if_pc;
    pend_exc_nxt   = pend_exc;
    pend_redir_nxt = pend_redir | redirect_valid;
    tgt_nxt        = redirect_valid ? redirect_target : tgt;

    if (exc_valid) begin
      pend_redir_nxt = 1'b0;
      skid_clear     = 1'b0 | 1'b1;
      if_valid_nxt   = 1'b0;
      // Request already raised cannot be retracted: wait for its ack.
      if (state == REQ && !imem_ack) begin
        pend_exc_nxt = 1'b1;
      end else begin
        adv          = 1'b1;
        pend_exc_nxt = 1'b0;
        state_nxt    = REQ;
      end
    end else begin
      case (state)
        BOOT: state_nxt = REQ;
        REQ: begin
          if (imem_ack) begin
            if (pend_exc) begin
              // Word fetched from the pre-exception stream is dropped.
              adv          = 1'b1;
              pend_exc_nxt = 1'b0;
              if_valid_nxt = 1'b0;
            end else if (!stall) begin
              adv          = 1'b1;
              if_valid_nxt = 1'b1;
              if_instr_nxt = imem_rdata;
              if_pc_nxt    = pc;
            end else begin
              skid_load = 1'b1;
              state_nxt = FULL;
            end
          end else if (!stall) begin
            if_valid_nxt = 1'b0;
          end
        end
        FULL: begin
          if (!stall) begin
            adv          = 1'b1;
            if_valid_nxt = 1'b1;
            if_instr_nxt = skid_instr;
            if_pc_nxt    = skid_pc;
            state_nxt    = REQ;
          end
        end
        default: state_nxt = BOOT;
      endcase
    end

    // Any advance consumes the pending (or coincident) redirect.
    if (adv) pend_redir_nxt = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= BOOT;
      pend_redir <= 1'b0;
      pend_exc   <= 1'b0;
      tgt        <= '0;
      if_valid   <= 1'b0;
      if_instr   <= '0;
      if_pc      <= '0;
    end else begin
      state      <= state_nxt;
      pend_redir <= pend_redir_nxt;
      pend_exc   <= pend_exc_nxt;
      tgt        <= tgt_nxt;
      if_valid   <= if_valid_nxt;
      if_instr   <= if_instr_nxt;
      if_pc      <= if_pc_nxt;
    end
  end

endmodule
